// File: rtl/panzer16_pkg.sv
// Shared definitions for the panzer16 fetch path: word geometry and the
// prefetch-FIFO reader state encoding.
package panzer16_pkg;

  localparam int DATA_W       = 16;
  localparam int IMM_FLAG_BIT = 15;

  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_OUT    = 2'd2
  } reader_state_t;

  // A first word with the flag bit set is followed by an immediate word.
  function automatic logic has_imm_flag(input logic [DATA_W-1:0] word);
    return word[IMM_FLAG_BIT];
  endfunction

endpackage

// File: rtl/fifo_instr_reader.sv
// Pops 16-bit words from a first-word-fall-through FIFO and assembles one- or
// two-word instructions for the decoder behind a valid/ready handshake.
module fifo_instr_reader
  import panzer16_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] FifoData,
  input  logic              FifoEmpty,
  output logic              FifoDequeue,
  input  logic              Flush,
  output logic [DATA_W-1:0] InstrWord,
  output logic [DATA_W-1:0] ImmWord,
  output logic              HasImm,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [15:0]       InstrCount
);

  reader_state_t     r_state;
  logic [DATA_W-1:0] r_instr_word;
  logic [DATA_W-1:0] r_imm_word;
  logic              r_has_imm;
  logic              r_instr_valid;
  logic [15:0]       r_instr_count;

  logic              w_dequeue;
  logic              w_accept;

  // A held instruction blocks further pops until the decoder takes it.
  assign w_dequeue = Rst && !Flush && !FifoEmpty && ((r_state != S_OUT) || InstrReady);
  assign w_accept  = (r_state == S_OUT) && InstrReady;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= S_FIRST;
      r_instr_word  <= '0;
      r_imm_word    <= '0;
      r_has_imm     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_count <= '0;
    end else if (Flush) begin
      r_state       <= S_FIRST;
      r_instr_word  <= '0;
      r_imm_word    <= '0;
      r_has_imm     <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr_count <= r_instr_count + 16'd1;
      end

      case (r_state)
        S_FIRST, S_OUT: begin
          if (w_dequeue) begin
            r_instr_word <= FifoData;
            if (has_imm_flag(FifoData)) begin
              r_state       <= S_SECOND;
              r_instr_valid <= 1'b0;
            end else begin
              r_state       <= S_OUT;
              r_has_imm     <= 1'b0;
              r_imm_word    <= '0;
              r_instr_valid <= 1'b1;
            end
          end else if (w_accept) begin
            r_state       <= S_FIRST;
            r_instr_valid <= 1'b0;
          end
        end

        S_SECOND: begin
          if (w_dequeue) begin
            r_state       <= S_OUT;
            r_imm_word    <= FifoData;
            r_has_imm     <= 1'b1;
            r_instr_valid <= 1'b1;
          end
        end

        default: begin
          r_state       <= S_FIRST;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign FifoDequeue = w_dequeue;
  assign InstrWord   = r_instr_word;
  assign ImmWord     = r_imm_word;
  assign HasImm      = r_has_imm;
  assign InstrValid  = r_instr_valid;
  assign InstrCount  = r_instr_count;

endmodule

// File: doc/fifo_instr_reader.md
# fifo_instr_reader

Read-side engine for the 4-slot prefetch FIFO (`Register_4Slot_Fifo`). It pops 16-bit words through the FIFO's `Dequeue`/`Empty` interface and assembles them into one-word or two-word instructions. Bit 15 of the first word flags a trailing immediate word. Each assembled instruction is presented to the decode stage with a valid/ready handshake. The block sits between the prefetch FIFO and the decoder, and drains the FIFO at up to one word per cycle.

## Interface
- `DATA_W`, 16, word width; must equal the FIFO width.
- `IMM_FLAG_BIT`, 15, bit of the first word that marks a following immediate word.
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `FifoData`  in  DATA_W  FIFO head word; valid whenever `FifoEmpty`=0 (first-word fall-through).
- `FifoEmpty`  in  1  FIFO empty flag.
- `FifoDequeue`  out  1  combinational pop request; the FIFO pops on the same rising edge.
- `Flush`  in  1  synchronous abort of the instruction being assembled or held.
- `InstrWord`  out  DATA_W  registered first word.
- `ImmWord`  out  DATA_W  registered immediate word; 0 when `HasImm`=0.
- `HasImm`  out  1  registered; instruction carries an immediate.
- `InstrValid`  out  1  registered; instruction outputs are stable and valid.
- `InstrReady`  in  1  decoder accepts the instruction on an edge where `InstrValid`=1.
- `InstrCount`  out  16  count of accepted instructions; wraps from 0xFFFF to 0.

## Operation
- **States:**
  - `S_FIRST`: awaiting the first word.
  - `S_SECOND`: first word held, awaiting the immediate.
  - `S_OUT`: instruction held, `InstrValid`=1.
- **Pop rule:** `FifoDequeue` = !`Flush` && !`FifoEmpty` && (state≠`S_OUT` || `InstrReady`). The block never asserts `FifoDequeue` while `FifoEmpty`=1.
- **`S_FIRST`, on a pop:**
  - `InstrWord`←`FifoData`.
  - If `FifoData[IMM_FLAG_BIT]`=1, go to `S_SECOND`.
  - Otherwise `HasImm`←0, `ImmWord`←0, go to `S_OUT`.
- **`S_SECOND`, on a pop:** `ImmWord`←`FifoData`, `HasImm`←1, go to `S_OUT`. With no pop, the state and outputs hold indefinitely.
- **`S_OUT` with `InstrReady`=1 (acceptance):**
  - `InstrCount` increments.
  - If the FIFO is non-empty, pop it and load exactly as in `S_FIRST` (stay in `S_OUT`, or go to `S_SECOND`).
  - If the FIFO is empty, go to `S_FIRST`.
- **`S_OUT` with `InstrReady`=0:** all outputs hold; no pop.
- **Flush (highest priority):**
  - Next state is `S_FIRST`; `InstrValid`, `HasImm`, `InstrWord` and `ImmWord` clear to 0.
  - No pop occurs in the flush cycle.
  - A held instruction is discarded and not counted, even if `InstrReady`=1 in that cycle.
  - A half-assembled first word is dropped.
  - The FIFO contents are untouched; the FIFO is flushed by its own reset.
- **Counter:** `InstrCount` is cleared only by `Rst`. `Flush` does not clear it.

## Timing
- **Reset (`Rst`=0, asynchronous):** state `S_FIRST`; `InstrValid`=0, `HasImm`=0, `InstrWord`=0, `ImmWord`=0, `InstrCount`=0. `FifoDequeue`=0 while reset is asserted.
- **One-word instruction:** popped at edge N, so `InstrValid`=1 after edge N (latency 1 cycle).
- **Two-word instruction:** words popped at edges N and N+1, so `InstrValid`=1 after N+1. A FIFO gap between the words extends the `S_SECOND` wait.
- **Throughput:** with the FIFO never empty, `InstrReady` held at 1 and only one-word instructions, one instruction is accepted per cycle with `InstrValid` continuously high.
- **Simultaneous acceptance and pop:** the new word replaces the outputs on the same edge. If the new word is a first word with bit 15 set, `InstrValid` drops for at least one cycle.
- **Simultaneous `Flush` and `Rst`:** reset dominates.

## Structure
- **Shared package** (`panzer16_pkg`): the `DATA_W` constant, the `IMM_FLAG_BIT` constant, and the `reader_state_t` enum (`S_FIRST`, `S_SECOND`, `S_OUT`).
- **Single module:** one FSM plus output registers, no sub-module.
- **Integration bench:** instantiate together with `Register_4Slot_Fifo`.

## Test plan
- **Reset mid-operation:** assert `Rst` low while in `S_OUT` holding 0x1234 → all outputs become 0 immediately, before the next edge; no pop occurs until `Rst` releases.
- **Streaming one-word:** enqueue 0x0001, 0x0002, 0x0003, 0x0004 with `InstrReady`=1 → `InstrWord` shows 1, 2, 3, 4 on consecutive cycles, `HasImm`=0, `InstrCount`=4, FIFO `Empty` afterwards.
- **Two-word with stall:** enqueue 0x8005 then 0xBEEF with `InstrReady`=0 for 3 cycles → `InstrWord`=0x8005, `ImmWord`=0xBEEF, `HasImm`=1 held stable, exactly 2 pops, count increments once on release.
- **Split immediate:** enqueue 0x8010, wait 5 cycles, then enqueue 0x00AA → `InstrValid` stays 0 during the gap and asserts the cycle after 0x00AA is popped.
- **Flush:** flush in `S_SECOND` after 0x8001 → no pop that cycle, state `S_FIRST`; a following 0x0007 emerges as a one-word instruction; count unchanged by the flush.
- **Counter wrap:** force 0xFFFF accepted instructions, then one more → `InstrCount`=0x0000.
